mask_centroid: RTL

Frame-level centroid extractor for the vision-gate pipeline. It sits directly downstream of the YCbCr threshold stage, which emits a 24-bit binary mask pixel: 24'hFFFFFF for foreground, 0 for background. The block counts foreground pixels per frame and accumulates their x/y coordinates. In vertical blanking it divides the sums sequentially to produce the object centroid, and it overlays a red crosshair at the last valid centroid on the passed-through video.

---
 rtl/mask_centroid.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mask_centroid.sv
// mask_centroid: per-frame foreground centroid of a binary mask stream.
// Accumulates count and x/y sums while video is active. In vertical blanking
// a shared restoring divider computes the floor centroid, and the passed-through
// video gets a red crosshair drawn at the last valid centroid.
module mask_centroid #(
  parameter  int IMG_W = 1280,
  parameter  int IMG_H = 720,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          de,
  input  logic          h_sync,
  input  logic          v_sync,
  input  logic [23:0]   pixel_in,
  output logic          de_out,
  output logic          h_sync_out,
  output logic          v_sync_out,
  output logic [23:0]   pixel_out,
  output logic [XW-1:0] x_c,
  output logic [YW-1:0] y_c,
  output logic          found,
  output logic          valid
);

  typedef enum logic [1:0] {ACC, DIV_X, DIV_Y, DONE} state_t;

  // video delay line and position of the delayed pixel
  logic          de_q, hs_q, vs_q;
  logic [23:0]   pix_q;
  logic [XW-1:0] xd_q;
  logic [YW-1:0] yd_q;
  // position counters and accumulators
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0]   cnt_q, cnt_d, sx_q, sx_d, sy_q, sy_d;
  // FSM, divider and result registers
  state_t        st_q, st_d;
  logic [31:0]   den_q, den_d, dvd_q, dvd_d, rem_q, rem_d, syl_q, syl_d;
  logic [4:0]    bit_q, bit_d;
  logic [XW-1:0] qx_q, qx_d, xc_q, xc_d;
  logic [YW-1:0] yc_q, yc_d;
  logic          fnx_q, fnx_d, found_q, found_d, valid_q, valid_d;

  logic          frame_end, fg;
  logic [32:0]   rem_sh;
  logic [31:0]   rem_nx, dvd_nx;
  logic          ge;

  assign frame_end = v_sync && !vs_q;
  assign fg        = de && (pixel_in[7:0] != 8'd0);

  // position counters and foreground accumulators (cleared at frame end)
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    cnt_d = cnt_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    if (v_sync) begin
      x_d = '0;
      y_d = '0;
    end else if (de) begin
      x_d = x_q + XW'(1);
    end else if (de_q) begin
      x_d = '0;
      y_d = y_q + YW'(1);
    end
    if (frame_end) begin
      cnt_d = '0;
      sx_d  = '0;
      sy_d  = '0;
    end else if (fg) begin
      cnt_d = cnt_q + 32'd1;
      sx_d  = sx_q + 32'(x_q);
      sy_d  = sy_q + 32'(y_q);
    end
  end

  // one restoring-division step: shift in next dividend bit, subtract if it fits
  always_comb begin
    rem_sh = {rem_q, dvd_q[31]};
    ge     = rem_sh >= {1'b0, den_q};
    rem_nx = ge ? (rem_sh[31:0] - den_q) : rem_sh[31:0];
    dvd_nx = {dvd_q[30:0], ge};
  end

  // FSM next state: latch sums at frame end, divide x then y, publish result
  always_comb begin
    st_d    = st_q;
    den_d   = den_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    syl_d   = syl_q;
    bit_d   = bit_q;
    qx_d    = qx_q;
    fnx_d   = fnx_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    found_d = found_q;
    valid_d = 1'b0;
    case (st_q)
      ACC: if (frame_end) begin
        den_d = cnt_q;
        dvd_d = sx_q;
        syl_d = sy_q;
        rem_d = '0;
        bit_d = '0;
        if (cnt_q != 32'd0) st_d = DIV_X;
        else begin
          st_d  = DONE;
          fnx_d = 1'b0;
        end
      end
      DIV_X: begin
        rem_d = rem_nx;
        dvd_d = dvd_nx;
        bit_d = bit_q + 5'd1;
        if (bit_q == 5'd31) begin
          // quotient complete: keep x, reload the divider with sum_y
          qx_d  = dvd_nx[XW-1:0];
          dvd_d = syl_q;
          rem_d = '0;
          st_d  = DIV_Y;
        end
      end
      DIV_Y: begin
        rem_d = rem_nx;
        dvd_d = dvd_nx;
        bit_d = bit_q + 5'd1;
        if (bit_q == 5'd31) begin
          st_d  = DONE;
          fnx_d = 1'b1;
        end
      end
      DONE: begin
        found_d = fnx_q;
        if (fnx_q) begin
          xc_d = qx_q;
          yc_d = dvd_q[YW-1:0];
        end
        valid_d = 1'b1;
        st_d    = ACC;
      end
      default: st_d = ACC;
    endcase
  end

  // video delay, counters and accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q  <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      pix_q <= '0;
      xd_q  <= '0;
      yd_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else begin
      de_q  <= de;
      hs_q  <= h_sync;
      vs_q  <= v_sync;
      pix_q <= pixel_in;
      xd_q  <= x_q;
      yd_q  <= y_q;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
    end
  end

  // FSM, divider and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ACC;
      den_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      syl_q   <= '0;
      bit_q   <= '0;
      qx_q    <= '0;
      fnx_q   <= 1'b0;
      xc_q    <= '0;
      yc_q    <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      den_q   <= den_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      syl_q   <= syl_d;
      bit_q   <= bit_d;
      qx_q    <= qx_d;
      fnx_q   <= fnx_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      found_q <= found_d;
      valid_q <= valid_d;
    end
  end

  assign de_out     = de_q;
  assign h_sync_out = hs_q;
  assign v_sync_out = vs_q;
  assign pixel_out  = (found_q && de_q && (xd_q == xc_q || yd_q == yc_q)) ? 24'hFF0000 : pix_q;
  assign x_c        = xc_q;
  assign y_c        = yc_q;
  assign found      = found_q;
  assign valid      = valid_q;

endmodule
